// File: rtl/alu_unit_pkg.sv
// Opcode and flag definitions shared by the ALU, its iterative datapath and its interface.
package alu_unit_pkg;

  typedef enum logic [3:0] {
    FnADD = 4'd0,
    FnADC,
    FnSUB,
    FnSBC,
    FnAND,
    FnOR,
    FnXOR,
    FnNOT,
    FnLSL,
    FnLSR,
    FnASR,
    FnMUL
  } alu_fn_t;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic isShift(alu_fn_t fn);
    return fn inside {FnLSL, FnLSR, FnASR};
  endfunction

endpackage

// File: rtl/alu_unit_if.sv
// Operation/result handshake bundle between decode, the ALU and writeback.
interface alu_unit_if #(
  parameter int WIDTH = 16
);
  logic                   InValid;
  logic                   InReady;
  alu_unit_pkg::alu_fn_t  Fn;
  logic [WIDTH-1:0]       OpA;
  logic [WIDTH-1:0]       OpB;
  logic                   SetFlags;
  logic                   OutValid;
  logic                   OutReady;
  logic [WIDTH-1:0]       Result;
  logic [3:0]             Flags;
  logic                   Illegal;

  modport master (
    output InValid, Fn, OpA, OpB, SetFlags, OutReady,
    input  InReady, OutValid, Result, Flags, Illegal
  );

  modport slave (
    input  InValid, Fn, OpA, OpB, SetFlags, OutReady,
    output InReady, OutValid, Result, Flags, Illegal
  );
endinterface

// File: rtl/alu_unit_iter.sv
// Iterative shift (1 bit/cycle) and shift-add multiply datapath; first step runs on start.
// The multiply path exists only when ALU_MUL_EN is defined.
module alu_iter
  import alu_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             start,
  input  alu_fn_t          fn,
  input  logic [WIDTH-1:0] opA,
`ifdef ALU_MUL_EN
  input  logic [WIDTH-1:0] opB,
`endif
  input  logic [SHW-1:0]   amt,
  output logic             done,
  output logic [WIDTH-1:0] accumulator,
  output logic             carryOut
);

  alu_fn_t          fnQ, curFn;
  logic [SHW-1:0]   cnt, cntLoad;
  logic [WIDTH-1:0] src, stepAcc;
  logic             stepC;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mcand, mplier, mcandSrc, mplierSrc;
`endif

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    curFn   = start ? fn : fnQ;
    src     = start ? opA : accumulator;
    stepAcc = src;
    stepC   = carryOut;
    cntLoad = amt - SHW'(1);
`ifdef ALU_MUL_EN
    mcandSrc  = start ? opA : mcand;
    mplierSrc = start ? opB : mplier;
    if (fn == FnMUL) cntLoad = SHW'(WIDTH - 1);
`endif
    case (curFn)
      FnLSL:   {stepC, stepAcc} = {src, 1'b0};
      FnLSR:   {stepAcc, stepC} = {1'b0, src};
      FnASR:   {stepAcc, stepC} = {src[WIDTH-1], src};
`ifdef ALU_MUL_EN
      FnMUL:   stepAcc = (start ? '0 : accumulator) + (mplierSrc[0] ? mcandSrc : '0);
`endif
      default: ;
    endcase
  end

  // NOTE: pure datapath, deliberately unreset; the controller ignores done outside SHIFT/MUL.
  always_ff @(posedge Clock) begin
    if (start || cnt != '0) begin
      fnQ         <= curFn;
      accumulator <= stepAcc;
      carryOut    <= stepC;
      cnt         <= start ? cntLoad : cnt - SHW'(1);
`ifdef ALU_MUL_EN
      mcand       <= mcandSrc << 1;
      mplier      <= mplierSrc >> 1;
`endif
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/alu_unit.sv
// Handshaked ALU with persistent Z/N/C/V flags, iterative shifts and optional multiply.
// Define ALU_MUL_EN to build the iterative multiplier; otherwise FnMUL reports Illegal.
module alu_unit
  import alu_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic       Clock,
  input logic       nReset,
  alu_unit_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, MUL} alu_state_t;

  alu_state_t       state;
  logic             setFlagsQ;
  logic             accept, iterStart, isMulFn;
  logic             iterDone, iterC;
  logic [WIDTH-1:0] iterAcc;
  logic [SHW-1:0]   shiftAmt;

  logic [WIDTH-1:0] res, opBX;
  logic [WIDTH:0]   sum;
  logic [3:0]       nextFlags;
  logic             cin, illegal;

  assign bus.InReady = (state == IDLE) && (!bus.OutValid || bus.OutReady);
  assign accept      = bus.InValid && bus.InReady;
  assign shiftAmt    = bus.OpB[SHW-1:0];
`ifdef ALU_MUL_EN
  assign isMulFn     = (bus.Fn == FnMUL);
`else
  assign isMulFn     = 1'b0;
`endif
  assign iterStart   = accept && ((isShift(bus.Fn) && shiftAmt != '0) || isMulFn);

  alu_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
    .Clock       (Clock),
    .start       (iterStart),
    .fn          (bus.Fn),
    .opA         (bus.OpA),
`ifdef ALU_MUL_EN
    .opB         (bus.OpB),
`endif
    .amt         (shiftAmt),
    .done        (iterDone),
    .accumulator (iterAcc),
    .carryOut    (iterC)
  );

  // Single-cycle result; shifts by zero land here and pass OpA through with C untouched.
  always_comb begin
    res       = '0;
    nextFlags = bus.Flags;
    illegal   = 1'b0;
    opBX      = bus.OpB;
    cin       = 1'b0;
    sum       = '0;
    case (bus.Fn)
      FnADD, FnADC, FnSUB, FnSBC: begin
        opBX = (bus.Fn == FnSUB || bus.Fn == FnSBC) ? ~bus.OpB : bus.OpB;
        cin  = (bus.Fn == FnADD) ? 1'b0 :
               (bus.Fn == FnSUB) ? 1'b1 : bus.Flags[FLAG_C];
        sum  = {1'b0, bus.OpA} + {1'b0, opBX} + (WIDTH+1)'(cin);
        res  = sum[WIDTH-1:0];
        nextFlags[FLAG_C] = sum[WIDTH];
        nextFlags[FLAG_V] = (bus.OpA[WIDTH-1] == opBX[WIDTH-1]) &&
                            (sum[WIDTH-1] != bus.OpA[WIDTH-1]);
      end
      FnAND:               res = bus.OpA & bus.OpB;
      FnOR:                res = bus.OpA | bus.OpB;
      FnXOR:               res = bus.OpA ^ bus.OpB;
      FnNOT:               res = ~bus.OpA;
      FnLSL, FnLSR, FnASR: res = bus.OpA;
      default:             illegal = 1'b1;
    endcase
    if (!illegal) begin
      nextFlags[FLAG_Z] = (res == '0);
      nextFlags[FLAG_N] = res[WIDTH-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state        <= IDLE;
      bus.OutValid <= 1'b0;
      bus.Result   <= '0;
      bus.Flags    <= '0;
      bus.Illegal  <= 1'b0;
      setFlagsQ    <= 1'b0;
    end else begin
      if (bus.OutValid && bus.OutReady) bus.OutValid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            setFlagsQ <= bus.SetFlags;
            if (iterStart) begin
              bus.Illegal <= 1'b0;
              state       <= isMulFn ? MUL : SHIFT;
            end else begin
              bus.Result   <= res;
              bus.OutValid <= 1'b1;
              bus.Illegal  <= illegal;
              if (bus.SetFlags) bus.Flags <= nextFlags;
            end
          end
        end
        SHIFT, MUL: begin
          if (iterDone) begin
            bus.Result   <= iterAcc;
            bus.OutValid <= 1'b1;
            state        <= IDLE;
            if (setFlagsQ) begin
              bus.Flags[FLAG_Z] <= (iterAcc == '0);
              bus.Flags[FLAG_N] <= iterAcc[WIDTH-1];
              if (state == SHIFT) bus.Flags[FLAG_C] <= iterC;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Directed-vector bench for alu_unit (WIDTH=16): arithmetic, logic, shifts, handshake,
// reset abort and the multiply/illegal behaviour of whichever ALU_MUL_EN build is compiled.
module tb_alu_unit;
  import alu_unit_pkg::*;

  logic Clock = 1'b0;
  logic nReset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   lat;
  bit   leak;

  alu_unit_if #(.WIDTH(16)) bus ();

  alu_unit #(.WIDTH(16)) dut (
    .Clock  (Clock),
    .nReset (nReset),
    .bus    (bus)
  );

  always #5 Clock = ~Clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Present one op, scramble inputs after accept, wait (bounded) for OutValid.
  task automatic run_op(input alu_fn_t fn, input logic [15:0] a, input logic [15:0] b,
                        input logic sf, output int latency, output bit readyLeak);
    int guard = 0;
    while (!bus.InReady && guard < 50) begin
      tick();
      guard++;
    end
    if (!bus.InReady) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_wait: InReady got %b want 1", bus.InReady);
    end
    bus.InValid  = 1'b1;
    bus.Fn       = fn;
    bus.OpA      = a;
    bus.OpB      = b;
    bus.SetFlags = sf;
    tick();
    bus.InValid  = 1'b0;
    bus.Fn       = FnADD;
    bus.OpA      = ~a;
    bus.OpB      = ~b;
    bus.SetFlags = ~sf;
    latency   = 1;
    readyLeak = 1'b0;
    while (!bus.OutValid && latency < 40) begin
      if (bus.InReady) readyLeak = 1'b1;
      tick();
      latency++;
    end
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    repeat (2) tick();
    vectors++; if (bus.OutValid !== 1'b0) begin miscompares++; $display("FAIL reset_outvalid: got %b want 0", bus.OutValid); end
    vectors++; if (bus.Result !== 16'h0) begin miscompares++; $display("FAIL reset_result: got %h want 0000", bus.Result); end
    vectors++; if (bus.Flags !== 4'h0) begin miscompares++; $display("FAIL reset_flags: got %h want 0", bus.Flags); end
    vectors++; if (bus.Illegal !== 1'b0) begin miscompares++; $display("FAIL reset_illegal: got %b want 0", bus.Illegal); end
    nReset = 1'b1;
    #1;
    vectors++; if (bus.InReady !== 1'b1) begin miscompares++; $display("FAIL reset_inready: got %b want 1", bus.InReady); end
  endtask

  task automatic test_arith();
    alu_fn_t     fns[6] = '{FnADD, FnADC, FnSUB, FnSUB, FnSUB, FnSBC};
    logic [15:0] av[6]  = '{16'hFFFF, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 16'h0005};
    logic [15:0] bv[6]  = '{16'h0001, 16'h0000, 16'h0001, 16'h0000, 16'h0001, 16'h0003};
    logic        sfv[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [15:0] er[6]  = '{16'h0000, 16'h0001, 16'h7FFF, 16'h0000, 16'hFFFF, 16'h0001};
    logic [3:0]  ef[6]  = '{4'hA, 4'h0, 4'h3, 4'h3, 4'h4, 4'h2};
    for (int i = 0; i < 6; i++) begin
      run_op(fns[i], av[i], bv[i], sfv[i], lat, leak);
      vectors++; if (bus.Result !== er[i]) begin miscompares++; $display("FAIL arith%0d_result: got %h want %h", i, bus.Result, er[i]); end
      vectors++; if (bus.Flags !== ef[i]) begin miscompares++; $display("FAIL arith%0d_flags: got %h want %h", i, bus.Flags, ef[i]); end
      vectors++; if (lat !== 1) begin miscompares++; $display("FAIL arith%0d_latency: got %0d want 1", i, lat); end
    end
  endtask

  task automatic test_logic();
    alu_fn_t     fns[4] = '{FnAND, FnOR, FnXOR, FnNOT};
    logic [15:0] av[4]  = '{16'hF0F0, 16'h0F00, 16'hFFFF, 16'h00FF};
    logic [15:0] bv[4]  = '{16'hFF00, 16'h00F0, 16'hFFFF, 16'h1234};
    logic [15:0] er[4]  = '{16'hF000, 16'h0FF0, 16'h0000, 16'hFF00};
    logic [3:0]  ef[4]  = '{4'h6, 4'h2, 4'hA, 4'h6};
    for (int i = 0; i < 4; i++) begin
      run_op(fns[i], av[i], bv[i], 1'b1, lat, leak);
      vectors++; if (bus.Result !== er[i]) begin miscompares++; $display("FAIL logic%0d_result: got %h want %h", i, bus.Result, er[i]); end
      vectors++; if (bus.Flags !== ef[i]) begin miscompares++; $display("FAIL logic%0d_flags: got %h want %h", i, bus.Flags, ef[i]); end
    end
  endtask

  task automatic test_shift();
    alu_fn_t     fns[4] = '{FnLSL, FnASR, FnLSR, FnLSL};
    logic [15:0] av[4]  = '{16'h8001, 16'h8000, 16'h0003, 16'h1234};
    logic [15:0] bv[4]  = '{16'h0003, 16'h000F, 16'h0001, 16'h0010};
    logic [15:0] er[4]  = '{16'h0008, 16'hFFFF, 16'h0001, 16'h1234};
    logic [3:0]  ef[4]  = '{4'h0, 4'h4, 4'h2, 4'h2};
    int          el[4]  = '{4, 16, 2, 1};
    for (int i = 0; i < 4; i++) begin
      run_op(fns[i], av[i], bv[i], 1'b1, lat, leak);
      vectors++; if (lat !== el[i]) begin miscompares++; $display("FAIL shift%0d_latency: got %0d want %0d", i, lat, el[i]); end
      vectors++; if (bus.Result !== er[i]) begin miscompares++; $display("FAIL shift%0d_result: got %h want %h", i, bus.Result, er[i]); end
      vectors++; if (bus.Flags !== ef[i]) begin miscompares++; $display("FAIL shift%0d_flags: got %h want %h", i, bus.Flags, ef[i]); end
      vectors++; if (leak !== 1'b0) begin miscompares++; $display("FAIL shift%0d_inready_busy: got %b want 0", i, leak); end
    end
  endtask

  task automatic test_back_to_back();
    tick();
    bus.OutReady = 1'b0;
    run_op(FnADD, 16'h0002, 16'h0003, 1'b0, lat, leak);
    bus.InValid = 1'b1;
    bus.Fn      = FnADD;
    bus.OpA     = 16'd10;
    bus.OpB     = 16'd20;
    for (int i = 0; i < 5; i++) begin
      vectors++; if (bus.Result !== 16'h0005 || bus.OutValid !== 1'b1) begin miscompares++; $display("FAIL hold%0d_result: got %h/%b want 0005/1", i, bus.Result, bus.OutValid); end
      vectors++; if (bus.InReady !== 1'b0) begin miscompares++; $display("FAIL hold%0d_inready: got %b want 0", i, bus.InReady); end
      tick();
    end
    bus.OutReady = 1'b1;
    #1;
    vectors++; if (bus.InReady !== 1'b1) begin miscompares++; $display("FAIL drain_inready: got %b want 1", bus.InReady); end
    tick();
    bus.InValid = 1'b0;
    vectors++; if (bus.OutValid !== 1'b1 || bus.Result !== 16'h001E) begin miscompares++; $display("FAIL drain_accept: got %h/%b want 001e/1", bus.Result, bus.OutValid); end
    tick();
    vectors++; if (bus.OutValid !== 1'b0) begin miscompares++; $display("FAIL drain_clear: got %b want 0", bus.OutValid); end
  endtask

  task automatic test_reset_mid_shift();
    int seen = 0;
    bus.InValid  = 1'b1;
    bus.Fn       = FnLSL;
    bus.OpA      = 16'hFFFF;
    bus.OpB      = 16'h000A;
    bus.SetFlags = 1'b1;
    tick();
    bus.InValid = 1'b0;
    repeat (3) tick();
    nReset = 1'b0;
    tick();
    nReset = 1'b1;
    #1;
    vectors++; if (bus.OutValid !== 1'b0) begin miscompares++; $display("FAIL abort_outvalid: got %b want 0", bus.OutValid); end
    vectors++; if (bus.Flags !== 4'h0) begin miscompares++; $display("FAIL abort_flags: got %h want 0", bus.Flags); end
    vectors++; if (bus.InReady !== 1'b1) begin miscompares++; $display("FAIL abort_inready: got %b want 1", bus.InReady); end
    vectors++; if (bus.Result !== 16'h0) begin miscompares++; $display("FAIL abort_result: got %h want 0000", bus.Result); end
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.OutValid) seen++;
    end
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL abort_stale: got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_mul();
    run_op(FnADD, 16'hFFFF, 16'h0001, 1'b1, lat, leak);
    run_op(FnADD, 16'h0001, 16'h0001, 1'b0, lat, leak);
    run_op(FnMUL, 16'd300, 16'd300, 1'b1, lat, leak);
`ifdef ALU_MUL_EN
    vectors++; if (lat !== 17) begin miscompares++; $display("FAIL mul_latency: got %0d want 17", lat); end
    vectors++; if (bus.Result !== 16'h5F90) begin miscompares++; $display("FAIL mul_result: got %h want 5f90", bus.Result); end
    vectors++; if (bus.Flags !== 4'h2) begin miscompares++; $display("FAIL mul_flags: got %h want 2", bus.Flags); end
    vectors++; if (bus.Illegal !== 1'b0) begin miscompares++; $display("FAIL mul_illegal: got %b want 0", bus.Illegal); end
`else
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL mul_latency: got %0d want 1", lat); end
    vectors++; if (bus.Result !== 16'h0000) begin miscompares++; $display("FAIL mul_result: got %h want 0000", bus.Result); end
    vectors++; if (bus.Flags !== 4'hA) begin miscompares++; $display("FAIL mul_flags: got %h want a", bus.Flags); end
    vectors++; if (bus.Illegal !== 1'b1) begin miscompares++; $display("FAIL mul_illegal: got %b want 1", bus.Illegal); end
`endif
  endtask

  task automatic test_illegal();
    run_op(FnADD, 16'hFFFF, 16'h0001, 1'b1, lat, leak);
    run_op(FnADD, 16'h0001, 16'h0001, 1'b0, lat, leak);
    run_op(alu_fn_t'(4'd13), 16'h1111, 16'h2222, 1'b1, lat, leak);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL illegal_latency: got %0d want 1", lat); end
    vectors++; if (bus.Result !== 16'h0000) begin miscompares++; $display("FAIL illegal_result: got %h want 0000", bus.Result); end
    vectors++; if (bus.Illegal !== 1'b1) begin miscompares++; $display("FAIL illegal_flag: got %b want 1", bus.Illegal); end
    vectors++; if (bus.Flags !== 4'hA) begin miscompares++; $display("FAIL illegal_flags: got %h want a", bus.Flags); end
    run_op(FnAND, 16'h0003, 16'h0001, 1'b0, lat, leak);
    vectors++; if (bus.Illegal !== 1'b0) begin miscompares++; $display("FAIL illegal_clear: got %b want 0", bus.Illegal); end
    vectors++; if (bus.Result !== 16'h0001) begin miscompares++; $display("FAIL illegal_next_result: got %h want 0001", bus.Result); end
  endtask

  initial begin
    bus.InValid  = 1'b0;
    bus.Fn       = FnADD;
    bus.OpA      = '0;
    bus.OpB      = '0;
    bus.SetFlags = 1'b0;
    bus.OutReady = 1'b1;
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_back_to_back();
    test_reset_mid_shift();
    test_mul();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
